// File: rtl/m_multiply_adder_arbiter.sv
// rtl/m_multiply_adder_arbiter.sv - round-robin shared 3-stage multiply-adder (y = COEF*b + c)
module m_multiply_adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int BW    = 16,
  parameter int CW    = 32,
  parameter int YW    = 32,
  parameter int COEF  = 3,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  w_clock,
  input  logic                  w_reset,
  input  logic [N_REQ-1:0]      w_req,
  input  logic [N_REQ*BW-1:0]   w_b_flat,
  input  logic [N_REQ*CW-1:0]   w_c_flat,
  output logic [N_REQ-1:0]      w_gnt,
  output logic                  r_y_valid,
  output logic [IDW-1:0]        r_y_id,
  output logic [YW-1:0]         r_y,
  input  logic                  w_y_ready,
  output logic                  r_busy,
  output logic [31:0]           r_issue_count
);

  localparam logic [CW-1:0] COEF_W = CW'(COEF);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  // Round-robin pointer: the requester searched first on the next arbitration.
  logic [IDW-1:0] r_ptr;

  // Stage 1: selected operands.
  logic           r_v1;
  logic [IDW-1:0] r_id1;
  logic [BW-1:0]  r_b1;
  logic [CW-1:0]  r_c1;

  // Stage 2: product and pass-through addend.
  logic           r_v2;
  logic [IDW-1:0] r_id2;
  logic [CW-1:0]  r_d;
  logic [CW-1:0]  r_e;

  logic           w_stall;
  logic           w_found;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_ptr_next;
  logic           w_issue;
  logic [BW-1:0]  w_b_sel;
  logic [CW-1:0]  w_c_sel;

  // The whole pipe freezes when a finished result cannot leave.
  assign w_stall = r_y_valid & ~w_y_ready;
  assign w_issue = |w_gnt;

  // Arbiter: first requester at or after r_ptr, wrapping; no grant while stalled.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_cand   = r_ptr;
    w_gnt    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_req[w_cand]) begin
        w_found  = 1'b1;
        w_gnt_id = w_cand;
      end
      w_cand = (w_cand == LAST_ID) ? '0 : w_cand + 1'b1;
    end
    if (w_found && !w_stall) begin
      w_gnt[w_gnt_id] = 1'b1;
    end
    w_ptr_next = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_b_sel = '0;
    w_c_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_b_sel = w_b_flat[i*BW +: BW];
        w_c_sel = w_c_flat[i*CW +: CW];
      end
    end
  end

  // Pointer advances past the winner; issue counter counts every grant.
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_ptr         <= '0;
      r_issue_count <= '0;
    end else if (w_issue) begin
      r_ptr         <= w_ptr_next;
      r_issue_count <= r_issue_count + 32'd1;
    end
  end

  // Stage 1: capture the granted operands (a bubble when nothing was granted).
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_v1  <= 1'b0;
      r_id1 <= '0;
      r_b1  <= '0;
      r_c1  <= '0;
    end else if (!w_stall) begin
      r_v1  <= w_issue;
      r_id1 <= w_gnt_id;
      r_b1  <= w_b_sel;
      r_c1  <= w_c_sel;
    end
  end

  // Stage 2: constant multiply, truncated to the product width.
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_v2  <= 1'b0;
      r_id2 <= '0;
      r_d   <= '0;
      r_e   <= '0;
    end else if (!w_stall) begin
      r_v2  <= r_v1;
      r_id2 <= r_id1;
      r_d   <= COEF_W * CW'(r_b1);
      r_e   <= r_c1;
    end
  end

  // Stage 3: final add into the result register, wrapping at the result width.
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_y_valid <= 1'b0;
      r_y_id    <= '0;
      r_y       <= '0;
    end else if (!w_stall) begin
      r_y_valid <= r_v2;
      r_y_id    <= r_id2;
      r_y       <= YW'({1'b0, r_d} + {1'b0, r_e});
    end
  end

  // Busy is registered from the next-state valids so it has no combinational input path.
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_busy <= 1'b0;
    end else if (!w_stall) begin
      r_busy <= w_issue | r_v1 | r_v2;
    end
  end

endmodule

// File: tb/tb_m_multiply_adder_arbiter.sv
// tb/tb_m_multiply_adder_arbiter.sv - randomized self-checking bench for m_multiply_adder_arbiter
module tb_m_multiply_adder_arbiter;

  localparam int N_REQ = 4;
  localparam int BW    = 16;
  localparam int CW    = 32;
  localparam int YW    = 32;
  localparam int COEF  = 3;
  localparam int IDW   = 2;

  logic                  w_clock = 1'b0;
  logic                  w_reset;
  logic [N_REQ-1:0]      w_req;
  logic [N_REQ*BW-1:0]   w_b_flat;
  logic [N_REQ*CW-1:0]   w_c_flat;
  logic [N_REQ-1:0]      w_gnt;
  logic                  r_y_valid;
  logic [IDW-1:0]        r_y_id;
  logic [YW-1:0]         r_y;
  logic                  w_y_ready;
  logic                  r_busy;
  logic [31:0]           r_issue_count;

  m_multiply_adder_arbiter #(
    .N_REQ(N_REQ), .BW(BW), .CW(CW), .YW(YW), .COEF(COEF), .IDW(IDW)
  ) dut (
    .w_clock(w_clock), .w_reset(w_reset), .w_req(w_req),
    .w_b_flat(w_b_flat), .w_c_flat(w_c_flat), .w_gnt(w_gnt),
    .r_y_valid(r_y_valid), .r_y_id(r_y_id), .r_y(r_y),
    .w_y_ready(w_y_ready), .r_busy(r_busy), .r_issue_count(r_issue_count)
  );

  always #5 w_clock = ~w_clock;

  typedef struct {
    int     id;
    longint y;
    int     stage;
  } op_t;

  op_t            q[$];
  int             m_ptr;
  longint         m_count;
  int             checks;
  int             errors;
  logic [BW-1:0]  b_arr [N_REQ];
  logic [CW-1:0]  c_arr [N_REQ];

  function automatic int arb(input logic [N_REQ-1:0] req, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (ptr + k) % N_REQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic longint ref_y(input longint b, input longint c);
    longint p;
    p = (COEF * b) % (64'sd1 <<< CW);
    return (p + c) % (64'sd1 <<< YW);
  endfunction

  function automatic void model_clear();
    q.delete();
    m_ptr   = 0;
    m_count = 0;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model across the edge.
  task automatic step(input logic [N_REQ-1:0] req, input logic ready, output int gid);
    logic             exp_valid;
    logic             stall;
    logic [N_REQ-1:0] exp_gnt;
    op_t              n;
    @(negedge w_clock);
    w_req     = req;
    w_y_ready = ready;
    for (int i = 0; i < N_REQ; i++) begin
      w_b_flat[i*BW +: BW] = b_arr[i];
      w_c_flat[i*CW +: CW] = c_arr[i];
    end
    #1;
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (q[0].stage == 3);
    stall   = exp_valid && !ready;
    gid     = stall ? -1 : arb(req, m_ptr);
    exp_gnt = (gid >= 0) ? (N_REQ'(1) << gid) : '0;
    checks++;
    if (w_gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt got %b want %b", w_gnt, exp_gnt);
    end
    checks++;
    if (r_y_valid !== exp_valid) begin
      errors++;
      $display("FAIL y_valid got %b want %b", r_y_valid, exp_valid);
    end
    checks++;
    if (r_busy !== (q.size() > 0)) begin
      errors++;
      $display("FAIL busy got %b want %b", r_busy, q.size() > 0);
    end
    checks++;
    if (r_issue_count !== 32'(m_count)) begin
      errors++;
      $display("FAIL issue_count got %0d want %0d", r_issue_count, 32'(m_count));
    end
    if (exp_valid) begin
      checks++;
      if (r_y !== YW'(q[0].y) || r_y_id !== IDW'(q[0].id)) begin
        errors++;
        $display("FAIL result got id %0d y %h want id %0d y %h", r_y_id, r_y, q[0].id, YW'(q[0].y));
      end
    end
    if (!stall) begin
      if (exp_valid) void'(q.pop_front());
      foreach (q[k]) q[k].stage++;
      if (gid >= 0) begin
        n.id    = gid;
        n.y     = ref_y(longint'(b_arr[gid]), longint'(c_arr[gid]));
        n.stage = 1;
        q.push_back(n);
        m_ptr = (gid + 1) % N_REQ;
        m_count++;
      end
    end
  endtask

  task automatic do_reset();
    w_reset   = 1'b1;
    w_req     = '0;
    w_y_ready = 1'b1;
    repeat (2) @(negedge w_clock);
    w_reset = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    int g;
    repeat (5) step('0, 1'b1, g);
  endtask

  task automatic test_reset();
    w_reset = 1'b1;
    w_req   = '0;
    #2;
    checks++;
    if (r_y_valid !== 1'b0 || r_busy !== 1'b0 || r_y !== '0 || r_y_id !== '0 || r_issue_count !== '0 || w_gnt !== '0) begin
      errors++;
      $display("FAIL reset_state got v %b busy %b y %h id %0d cnt %0d gnt %b want all 0",
               r_y_valid, r_busy, r_y, r_y_id, r_issue_count, w_gnt);
    end
    @(negedge w_clock);
    w_reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    int g;
    do_reset();
    b_arr[0] = 16'd1;
    c_arr[0] = 32'd2;
    step(4'b0001, 1'b1, g);
    step('0, 1'b1, g);
    step('0, 1'b1, g);
    step('0, 1'b1, g);
    checks++;
    if (r_y_valid !== 1'b1 || r_y !== 32'd5 || r_y_id !== 2'd0) begin
      errors++;
      $display("FAIL single_latency got v %b y %0d id %0d want v 1 y 5 id 0", r_y_valid, r_y, r_y_id);
    end
    step('0, 1'b1, g);
    checks++;
    if (r_y_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle got v %b want 0", r_y_valid);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      b_arr[i] = BW'($urandom);
      c_arr[i] = $urandom;
    end
    for (int n = 0; n < 12; n++) begin
      step(4'hF, 1'b1, g);
      checks++;
      if (g !== n % N_REQ) begin
        errors++;
        $display("FAIL rr_order got %0d want %0d", g, n % N_REQ);
      end
      if (g >= 0) begin
        b_arr[g] = BW'($urandom);
        c_arr[g] = $urandom;
      end
    end
    drain();
  endtask

  task automatic test_stall();
    int g;
    do_reset();
    b_arr[2] = 16'd5;
    c_arr[2] = 32'd6;
    b_arr[0] = BW'($urandom);
    c_arr[0] = $urandom;
    step(4'b0100, 1'b1, g);
    step('0, 1'b1, g);
    step('0, 1'b1, g);
    for (int n = 0; n < 4; n++) begin
      step(4'b0001, 1'b0, g);
      checks++;
      if (r_y !== 32'd21 || r_y_id !== 2'd2 || w_gnt !== '0) begin
        errors++;
        $display("FAIL stall_hold got y %0d id %0d gnt %b want y 21 id 2 gnt 0", r_y, r_y_id, w_gnt);
      end
    end
    step(4'b0001, 1'b1, g);
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL stall_resume got %0d want 0", g);
    end
    drain();
  endtask

  task automatic test_wrap();
    int g;
    do_reset();
    b_arr[1] = 16'hFFFF;
    c_arr[1] = 32'hFFFFFFFF;
    step(4'b0010, 1'b1, g);
    step('0, 1'b1, g);
    step('0, 1'b1, g);
    step('0, 1'b1, g);
    checks++;
    if (r_y !== 32'h0002FFFC || r_y_id !== 2'd1) begin
      errors++;
      $display("FAIL wrap_sum got y %h id %0d want y 0002fffc id 1", r_y, r_y_id);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int g;
    do_reset();
    for (int n = 0; n < 3; n++) step(4'hF, 1'b1, g);
    @(posedge w_clock);
    #2;
    w_req   = '0;
    w_reset = 1'b1;
    #1;
    checks++;
    if (r_y_valid !== 1'b0 || r_busy !== 1'b0 || r_y !== '0 || r_y_id !== '0 || r_issue_count !== '0) begin
      errors++;
      $display("FAIL midflight_reset got v %b busy %b y %h id %0d cnt %0d want all 0",
               r_y_valid, r_busy, r_y, r_y_id, r_issue_count);
    end
    model_clear();
    @(negedge w_clock);
    w_reset = 1'b0;
    for (int n = 0; n < 5; n++) step('0, 1'b1, g);
    step(4'b1001, 1'b1, g);
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL ptr_restart got %0d want 0", g);
    end
    drain();
  endtask

  task automatic test_ptr_wrap();
    int g;
    do_reset();
    step(4'b0010, 1'b1, g);
    step(4'b1010, 1'b1, g);
    checks++;
    if (g !== 3) begin
      errors++;
      $display("FAIL ptr_wrap_first got %0d want 3", g);
    end
    step(4'b0010, 1'b1, g);
    checks++;
    if (g !== 1) begin
      errors++;
      $display("FAIL ptr_wrap_second got %0d want 1", g);
    end
    drain();
  endtask

  task automatic test_random();
    int               g;
    logic [N_REQ-1:0] pend;
    logic             rdy;
    pend = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          b_arr[i] = ($urandom_range(0, 7) == 0) ? '1 : BW'($urandom);
          c_arr[i] = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      step(pend, rdy, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    drain();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    w_reset   = 1'b1;
    w_req     = '0;
    w_y_ready = 1'b1;
    w_b_flat  = '0;
    w_c_flat  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      b_arr[i] = '0;
      c_arr[i] = '0;
    end
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_midflight();
    test_ptr_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
